wave_feature_ext: RTL and testbench



---
 rtl/wave_feature_ext_if.sv | 29 ++
 rtl/wave_feature_ext.sv | 199 +++++++++++++++++++
 tb/tb_wave_feature_ext.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_feature_ext_if.sv
// Sample/result bundle for wave_feature_ext: the sampled waveform and gate flow in,
// the busy flag, the feat_valid strobe and the held result set flow out.
interface wave_feature_ext_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 16
);
    logic                  gate;
    logic                  sample_valid;
    logic [DW-1:0]         sample;
    logic                  busy;
    logic                  feat_valid;
    logic [DW-1:0]         vmin;
    logic [DW-1:0]         vmax;
    logic [CNT_W-1:0]      n_samples;
    logic [CNT_W-1:0]      n_jump;
    logic [CNT_W-1:0]      n_flat;
    logic [CNT_W-1:0]      n_slope_chg;
    logic [DW+CNT_W-1:0]   vsum;

    modport master (
        output gate, sample_valid, sample,
        input  busy, feat_valid, vmin, vmax, n_samples, n_jump, n_flat, n_slope_chg, vsum
    );

    modport slave (
        input  gate, sample_valid, sample,
        output busy, feat_valid, vmin, vmax, n_samples, n_jump, n_flat, n_slope_chg, vsum
    );
endinterface

// File: rtl/wave_feature_ext.sv
// Gated waveform feature extractor: min/max, sample/step/flat/slope-reversal counts per gate window.
// Define WFE_SUM_EN to build the saturating sample-sum accumulator; otherwise vsum reads 0.
module wave_feature_ext #(
    parameter int unsigned DW      = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned JUMP_TH = 32,
    parameter int unsigned FLAT_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    wave_feature_ext_if.slave bus
);
    localparam int unsigned SW       = DW + CNT_W;
    localparam logic [DW:0] JUMP_LIM = (DW+1)'(JUMP_TH);
    localparam logic [DW:0] FLAT_LIM = (DW+1)'(FLAT_TH);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic             gate_dly_q;
    logic             rise, fall, clr, first_acc, run_acc, load_out;
    logic [DW:0]      delta, mag;
    logic             is_jump, is_flat;

    logic [DW-1:0]    min_q, min_d, max_q, max_d, prev_q, prev_d;
    logic [CNT_W-1:0] ns_q, ns_d, nj_q, nj_d, nf_q, nf_d, nc_q, nc_d;
    logic             sgn_vld_q, sgn_vld_d, sgn_q, sgn_d;
    logic [DW-1:0]    omin_q, omin_d, omax_q, omax_d;
    logic [CNT_W-1:0] ons_q, ons_d, onj_q, onj_d, onf_q, onf_d, onc_q, onc_d;
    logic             fv_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rise      = bus.gate & ~gate_dly_q;
    assign fall      = ~bus.gate & gate_dly_q;
    assign first_acc = (state_q == S_ARM) & ~fall & bus.sample_valid;
    assign run_acc   = (state_q == S_RUN) & ~fall & bus.sample_valid;
    assign clr       = rise & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign load_out  = (state_q == S_DONE);

    // Delta is formed in DW+1 bits so its MSB is the sign; magnitude is the two's-complement abs.
    assign delta   = {1'b0, bus.sample} - {1'b0, prev_q};
    assign mag     = delta[DW] ? (~delta + 1'b1) : delta;
    assign is_jump = (mag >= JUMP_LIM);
    assign is_flat = (mag <= FLAT_LIM);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rise) state_d = S_ARM;
            S_ARM: begin
                if (fall)                  state_d = S_DONE;
                else if (bus.sample_valid) state_d = S_RUN;
            end
            S_RUN:   if (fall) state_d = S_DONE;
            S_DONE:  state_d = rise ? S_ARM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        min_d     = min_q;
        max_d     = max_q;
        prev_d    = prev_q;
        ns_d      = ns_q;
        nj_d      = nj_q;
        nf_d      = nf_q;
        nc_d      = nc_q;
        sgn_vld_d = sgn_vld_q;
        sgn_d     = sgn_q;
        omin_d    = omin_q;
        omax_d    = omax_q;
        ons_d     = ons_q;
        onj_d     = onj_q;
        onf_d     = onf_q;
        onc_d     = onc_q;
        if (clr) begin
            min_d     = '0;
            max_d     = '0;
            prev_d    = '0;
            ns_d      = '0;
            nj_d      = '0;
            nf_d      = '0;
            nc_d      = '0;
            sgn_vld_d = 1'b0;
            sgn_d     = 1'b0;
        end else if (first_acc) begin
            min_d  = bus.sample;
            max_d  = bus.sample;
            prev_d = bus.sample;
            ns_d   = CNT_W'(1);
        end else if (run_acc) begin
            if (bus.sample < min_q) min_d = bus.sample;
            if (bus.sample > max_q) max_d = bus.sample;
            prev_d = bus.sample;
            ns_d   = sat_inc(ns_q);
            if (is_jump) nj_d = sat_inc(nj_q);
            // Flat deltas leave the remembered slope direction untouched.
            if (is_flat) begin
                nf_d = sat_inc(nf_q);
            end else begin
                if (sgn_vld_q && (delta[DW] != sgn_q)) nc_d = sat_inc(nc_q);
                sgn_d     = delta[DW];
                sgn_vld_d = 1'b1;
            end
        end
        if (load_out) begin
            omin_d = min_q;
            omax_d = max_q;
            ons_d  = ns_q;
            onj_d  = nj_q;
            onf_d  = nf_q;
            onc_d  = nc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gate_dly_q <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            prev_q     <= '0;
            ns_q       <= '0;
            nj_q       <= '0;
            nf_q       <= '0;
            nc_q       <= '0;
            sgn_vld_q  <= 1'b0;
            sgn_q      <= 1'b0;
            omin_q     <= '0;
            omax_q     <= '0;
            ons_q      <= '0;
            onj_q      <= '0;
            onf_q      <= '0;
            onc_q      <= '0;
            fv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_dly_q <= bus.gate;
            min_q      <= min_d;
            max_q      <= max_d;
            prev_q     <= prev_d;
            ns_q       <= ns_d;
            nj_q       <= nj_d;
            nf_q       <= nf_d;
            nc_q       <= nc_d;
            sgn_vld_q  <= sgn_vld_d;
            sgn_q      <= sgn_d;
            omin_q     <= omin_d;
            omax_q     <= omax_d;
            ons_q      <= ons_d;
            onj_q      <= onj_d;
            onf_q      <= onf_d;
            onc_q      <= onc_d;
            fv_q       <= load_out;
        end
    end

`ifdef WFE_SUM_EN
    logic [SW-1:0] sum_q, sum_d, osum_q, osum_d;
    logic [SW:0]   sum_add;

    assign sum_add = {1'b0, sum_q} + (SW+1)'(bus.sample);

    always_comb begin
        sum_d  = sum_q;
        osum_d = osum_q;
        if (clr)            sum_d = '0;
        else if (first_acc) sum_d = SW'(bus.sample);
        else if (run_acc)   sum_d = sum_add[SW] ? '1 : sum_add[SW-1:0];
        if (load_out)       osum_d = sum_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            osum_q <= '0;
        end else begin
            sum_q  <= sum_d;
            osum_q <= osum_d;
        end
    end

    assign bus.vsum = osum_q;
`else
    assign bus.vsum = '0;
`endif

    assign bus.busy        = (state_q == S_ARM) | (state_q == S_RUN);
    assign bus.feat_valid  = fv_q;
    assign bus.vmin        = omin_q;
    assign bus.vmax        = omax_q;
    assign bus.n_samples   = ons_q;
    assign bus.n_jump      = onj_q;
    assign bus.n_flat      = onf_q;
    assign bus.n_slope_chg = onc_q;
endmodule

// File: tb/tb_wave_feature_ext.sv
// Bench for wave_feature_ext: window-level reference model (per-window sample list reduced with
// plain arithmetic) checked every cycle, plus directed windows with hand-computed results.
module tb_wave_feature_ext;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       gate = 1'b0;
    logic       sv = 1'b0;
    logic [7:0] smp = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int fvc     = 0;

    always #5 clk = ~clk;

    wave_feature_ext_if #(.DW(8), .CNT_W(16)) bus ();
    wave_feature_ext_if #(.DW(8), .CNT_W(4))  bus4 ();

    assign bus.gate          = gate;
    assign bus.sample_valid  = sv;
    assign bus.sample        = smp;
    assign bus4.gate         = gate;
    assign bus4.sample_valid = sv;
    assign bus4.sample       = smp;

    wave_feature_ext #(.DW(8), .CNT_W(16), .JUMP_TH(32), .FLAT_TH(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    wave_feature_ext #(.DW(8), .CNT_W(4), .JUMP_TH(32), .FLAT_TH(1)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] win_q[$];
    bit m_prev_gate = 0, m_open = 0, m_pend = 0, e_fv = 0;
    longint unsigned e_min = 0, e_max = 0, e_ns = 0, e_nj = 0, e_nf = 0, e_nc = 0, e_sum = 0;

    function automatic void model_close();
        longint unsigned n, s;
        int mn, mx, nj, nf, nc, d, ad;
        bit have, last, neg;
        n = win_q.size(); s = 0; mn = 0; mx = 0; nj = 0; nf = 0; nc = 0; have = 0; last = 0;
        foreach (win_q[i]) begin
            s += longint'(win_q[i]);
            if (i == 0) begin
                mn = int'(win_q[i]);
                mx = int'(win_q[i]);
            end else begin
                if (int'(win_q[i]) < mn) mn = int'(win_q[i]);
                if (int'(win_q[i]) > mx) mx = int'(win_q[i]);
                d  = int'(win_q[i]) - int'(win_q[i-1]);
                ad = (d < 0) ? -d : d;
                if (ad >= 32) nj++;
                if (ad <= 1) nf++;
                else begin
                    neg = (d < 0);
                    if (have && neg != last) nc++;
                    last = neg;
                    have = 1;
                end
            end
        end
        e_min = mn; e_max = mx;
        e_ns  = (n  > 65535) ? 65535 : n;
        e_nj  = (nj > 65535) ? 65535 : nj;
        e_nf  = (nf > 65535) ? 65535 : nf;
        e_nc  = (nc > 65535) ? 65535 : nc;
`ifdef WFE_SUM_EN
        e_sum = (s > 64'hFF_FFFF) ? 64'hFF_FFFF : s;
`else
        e_sum = 0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev_gate = 0; m_open = 0; m_pend = 0; e_fv = 0;
            e_min = 0; e_max = 0; e_ns = 0; e_nj = 0; e_nf = 0; e_nc = 0; e_sum = 0;
            win_q.delete();
        end else begin
            e_fv = 0;
            if (m_pend) begin
                model_close();
                e_fv = 1; m_pend = 0;
                if (gate && !m_prev_gate) begin m_open = 1; win_q.delete(); end
            end else if (m_open) begin
                if (!gate) begin m_open = 0; m_pend = 1; end
                else if (sv) win_q.push_back(smp);
            end else if (gate && !m_prev_gate) begin
                m_open = 1; win_q.delete();
            end
            m_prev_gate = gate;
        end
    end

    always @(negedge clk) begin
        chk("busy",        bus.busy,        m_open);
        chk("feat_valid",  bus.feat_valid,  e_fv);
        chk("vmin",        bus.vmin,        e_min);
        chk("vmax",        bus.vmax,        e_max);
        chk("n_samples",   bus.n_samples,   e_ns);
        chk("n_jump",      bus.n_jump,      e_nj);
        chk("n_flat",      bus.n_flat,      e_nf);
        chk("n_slope_chg", bus.n_slope_chg, e_nc);
        chk("vsum",        bus.vsum,        e_sum);
        if (bus.feat_valid === 1'b1) fvc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic g, input logic v, input logic [7:0] s);
        @(negedge clk);
        gate = g; sv = v; smp = s;
    endtask

    task automatic close_chk(input string tag);
        drive(0, 0, 0);
        @(negedge clk);
        chk({tag, "_fv_early"}, bus.feat_valid, 0);
        @(negedge clk);
        chk({tag, "_fv_latency"}, bus.feat_valid, 1);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #2 rst = 1'b1; gate = 0; sv = 0;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic rand_window(input int len);
        int v, d, mode;
        v = $urandom_range(0, 255);
        drive(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < len; i++) begin
            mode = $urandom_range(0, 5);
            case (mode)
                0: d = 0;
                1: d = $urandom_range(0, 1) ? 1 : -1;
                2: d = $urandom_range(0, 1) ? 2 : -2;
                3: d = ($urandom_range(0, 1) ? 1 : -1) * (31 + int'($urandom_range(0, 2)));
                default: d = int'($urandom_range(0, 255)) - v;
            endcase
            v = v + d;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            drive(1, 1'($urandom_range(0, 3) != 0), 8'(v));
        end
        repeat ($urandom_range(1, 3)) drive(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    endtask

    initial begin
        int f0;
        #500000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        int f0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fv", bus.feat_valid, 0);
        chk("rst_nsamp", bus.n_samples, 0);
        chk("rst_vmax", bus.vmax, 0);
        #2 rst = 1'b0;
        repeat (2) drive(0, 0, 0);

        // ramp 0..252
        drive(1, 0, 0);
        for (int i = 0; i < 64; i++) drive(1, 1, 8'(i * 4));
        close_chk("ramp");
        chk("ramp_vmin", bus.vmin, 0);
        chk("ramp_vmax", bus.vmax, 252);
        chk("ramp_ns", bus.n_samples, 64);
        chk("ramp_nj", bus.n_jump, 0);
        chk("ramp_nf", bus.n_flat, 0);
        chk("ramp_nc", bus.n_slope_chg, 0);
`ifdef WFE_SUM_EN
        chk("ramp_vsum", bus.vsum, 8064);
`else
        chk("ramp_vsum", bus.vsum, 0);
`endif
        repeat (2) drive(0, 0, 0);

        // square 64/192, 8 samples per level
        drive(1, 0, 0);
        for (int i = 0; i < 32; i++) drive(1, 1, ((i / 8) % 2 == 0) ? 8'd64 : 8'd192);
        close_chk("sq");
        chk("sq_nj", bus.n_jump, 3);
        chk("sq_nf", bus.n_flat, 28);
        chk("sq_nc", bus.n_slope_chg, 2);
        chk("sq_vmin", bus.vmin, 64);
        chk("sq_vmax", bus.vmax, 192);
        chk("sq_ns", bus.n_samples, 32);
        repeat (2) drive(0, 0, 0);

        // empty window
        repeat (5) drive(1, 0, 8'd77);
        close_chk("empty");
        chk("empty_vmax", bus.vmax, 0);
        chk("empty_vmin", bus.vmin, 0);
        chk("empty_ns", bus.n_samples, 0);
        chk("empty_nf", bus.n_flat, 0);
        repeat (2) drive(0, 0, 0);

        // 20-sample ramp against the CNT_W=4 instance
        drive(1, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 1, 8'(i * 4));
        close_chk("r20");
        chk("r20_ns4", bus4.n_samples, 15);
        chk("r20_fv4", bus4.feat_valid, 1);
        chk("r20_vmax4", bus4.vmax, 76);
`ifdef WFE_SUM_EN
        chk("r20_vsum4", bus4.vsum, 760);
`else
        chk("r20_vsum4", bus4.vsum, 0);
`endif
        repeat (2) drive(0, 0, 0);

        // two windows separated by a single low cycle
        @(negedge clk); f0 = fvc;
        drive(1, 0, 0);
        for (int i = 0; i < 6; i++) drive(1, 1, 8'($urandom_range(0, 255)));
        drive(0, 1, 8'd200);
        drive(1, 1, 8'd200);
        drive(1, 1, 8'd10);
        drive(1, 1, 8'd10);
        drive(1, 1, 8'd50);
        drive(1, 1, 8'd50);
        drive(1, 1, 8'd10);
        close_chk("win2");
        chk("win2_ns", bus.n_samples, 5);
        chk("win2_nf", bus.n_flat, 2);
        chk("win2_nj", bus.n_jump, 2);
        chk("win2_nc", bus.n_slope_chg, 1);
        chk("win2_vmin", bus.vmin, 10);
        chk("win2_vmax", bus.vmax, 50);
        @(negedge clk);
        chk("win2_pulses", fvc - f0, 2);
        repeat (2) drive(0, 0, 0);

        // reset mid-RUN, then a flat window
        @(negedge clk); f0 = fvc;
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 8'(i * 50));
        pulse_rst();
        chk("rst_mid_busy", bus.busy, 0);
        repeat (3) drive(0, 0, 0);
        chk("rst_mid_nofv", fvc - f0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 8'd100);
        close_chk("flat");
        chk("flat_nf", bus.n_flat, 9);
        chk("flat_vmin", bus.vmin, 100);
        chk("flat_vmax", bus.vmax, 100);
        chk("flat_ns", bus.n_samples, 10);
        @(negedge clk);
        chk("flat_pulses", fvc - f0, 1);

        // randomized windows, checked cycle by cycle against the model
        for (int w = 0; w < 60; w++) rand_window($urandom_range(0, 40));
        repeat (4) drive(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
